line_window: RTL

LINE_WINDOW -- requirements
Module: line_window

---
 rtl/line_window_pkg.sv | 14 +
 rtl/bit_line_buf.sv | 28 ++
 rtl/line_window.sv | 84 ++++++++
 3 files changed

// File: rtl/line_window_pkg.sv
// rtl/line_window_pkg.sv - shared constants and helpers for the 3-row binary line window
package line_window_pkg;
  localparam int NI_L1  = 28;
  localparam int NI_L2  = 12;
  localparam int K      = 3;
  localparam int MAX_NI = 28;
  localparam int CNT_W  = 5;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t ni_of(input logic layer_sel);
    return layer_sel ? cnt_t'(NI_L2) : cnt_t'(NI_L1);
  endfunction
endpackage

// File: rtl/bit_line_buf.sv
// rtl/bit_line_buf.sv - 1-bit shift-register delay line with runtime tap select
module bit_line_buf
  import line_window_pkg::*;
#(
  parameter int DEPTH = MAX_NI
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic din,
  input  cnt_t tap_sel,
  output logic dout
);
  logic [DEPTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (en) sr_d = {sr_q[DEPTH-2:0], din};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  // tap_sel = Ni-1 yields the pixel pushed exactly Ni accepts ago
  assign dout = sr_q[tap_sel];
endmodule

// File: rtl/line_window.sv
// rtl/line_window.sv - streams a K=3 row window column per accepted pixel for 28x28 or 12x12 frames
module line_window #(
  parameter int K      = line_window_pkg::K,
  parameter int MAX_NI = line_window_pkg::MAX_NI
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         din_valid,
  input  logic         din,
  input  logic         state,
  output logic [K-1:0] taps,
  output logic         taps_valid,
  output logic         conv_start,
  output logic         frame_done
);
  import line_window_pkg::*;

  cnt_t         col_q, col_d, row_q, row_d, ni_q, ni_d;
  logic [K-1:0] taps_q, taps_d;
  logic         tv_q, tv_d, cs_q, cs_d, fd_q, fd_d;
  logic         first_px, last_col, last_px, buf_a_out, buf_b_out;
  cnt_t         ni_cur, tap_sel;

  always_comb begin
    first_px = (row_q == '0) && (col_q == '0);
    ni_cur   = first_px ? ni_of(state) : ni_q;
    tap_sel  = ni_cur - cnt_t'(1);
    last_col = (col_q == tap_sel);
    last_px  = last_col && (row_q == tap_sel);

    col_d  = col_q;
    row_d  = row_q;
    ni_d   = ni_q;
    taps_d = taps_q;
    tv_d   = 1'b0;
    fd_d   = 1'b0;
    cs_d   = cs_q;
    if (din_valid) begin
      ni_d   = ni_cur;
      taps_d = {buf_b_out, buf_a_out, din};
      tv_d   = (row_q >= cnt_t'(2));
      fd_d   = last_px;
      col_d  = last_col ? '0 : col_q + cnt_t'(1);
      if (last_col) row_d = last_px ? '0 : row_q + cnt_t'(1);
      if (first_px) cs_d = 1'b1;
    end else if (fd_q) begin
      // a pixel arriving on the frame_done cycle keeps conv_start high
      cs_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col_q  <= '0;
      row_q  <= '0;
      ni_q   <= cnt_t'(NI_L1);
      taps_q <= '0;
      tv_q   <= 1'b0;
      cs_q   <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      ni_q   <= ni_d;
      taps_q <= taps_d;
      tv_q   <= tv_d;
      cs_q   <= cs_d;
      fd_q   <= fd_d;
    end
  end

  bit_line_buf #(.DEPTH(MAX_NI)) u_buf_a (
    .clk(clk), .rstn(rstn), .en(din_valid), .din(din), .tap_sel(tap_sel), .dout(buf_a_out)
  );

  bit_line_buf #(.DEPTH(MAX_NI)) u_buf_b (
    .clk(clk), .rstn(rstn), .en(din_valid), .din(buf_a_out), .tap_sel(tap_sel), .dout(buf_b_out)
  );

  assign taps       = taps_q;
  assign taps_valid = tv_q;
  assign conv_start = cs_q;
  assign frame_done = fd_q;
endmodule
